// File: rtl/fsqrt_fmt_pkg.sv
// ============================================================================
// Module  : fsqrt_fmt_pkg
// Purpose : Formats and constants for the (wE=3, wF=3) fsqrt result drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fsqrt_fmt_pkg;

  localparam int WE   = 3;
  localparam int WF   = 3;
  localparam int BIAS = 3;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  // All-ones biased exponent: infinity in the output format.
  localparam logic [WE-1:0] EXP_MAX = WE'(2 * BIAS + 1);

  typedef struct packed {
    logic [1:0]    exn;
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } flopoco_t;

  typedef struct packed {
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } ieee_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } flags_t;

  localparam ieee_t CANON_NAN = '{sign: 1'b0, exp: 3'b111, frac: 3'b100};

  localparam int OUT_W = $bits(flags_t) + $bits(ieee_t);

endpackage

`default_nettype wire

// File: rtl/fsqrt_drain_3_3_if.sv
// ============================================================================
// Module  : fsqrt_drain_3_3_if
// Purpose : Core-result input and valid/ready output bundle of the drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fsqrt_drain_3_3_if;
  logic       x_valid;
  logic       issue_ok;
  logic [8:0] r;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic [2:0] out_flags;

  modport master (
    output x_valid, r, out_ready,
    input  issue_ok, out_valid, out_data, out_flags
  );

  modport slave (
    input  x_valid, r, out_ready,
    output issue_ok, out_valid, out_data, out_flags
  );
endinterface

`default_nettype wire

// File: rtl/fsqrt_drain_fifo.sv
// ============================================================================
// Module  : fsqrt_drain_fifo
// Purpose : Generic show-ahead synchronous FIFO with occupancy count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fsqrt_drain_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] din,
  input  wire logic             pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  valid,
  output logic [AW:0]           count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~w_empty;
  assign w_do_push = push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Head is forced to zero when empty so the outputs are clean after reset.
  assign dout  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign valid = ~w_empty;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fsqrt_drain_3_3.sv
// ============================================================================
// Module  : fsqrt_drain_3_3
// Purpose : Tracks fsqrt core issues, converts results to IEEE-style words,
//           buffers them with credit-based flow control.
//           Optional statistics enabled by FSQRT_DRAIN_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fsqrt_drain_3_3
  import fsqrt_fmt_pkg::*;
#(
  parameter int CORE_LAT = 1,
  parameter int DEPTH    = 4
`ifdef FSQRT_DRAIN_STATS_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fsqrt_drain_3_3_if.slave  bus
`ifdef FSQRT_DRAIN_STATS_EN
  , output logic [CNT_W-1:0] nan_cnt
  , output logic [CNT_W-1:0] ovf_cnt
  , output logic             drop_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CORE_LAT-1:0] r_vld_dly;
  logic                r_cnv_valid;
  ieee_t               r_cnv_data;
  flags_t              r_cnv_flags;

  flopoco_t            w_r;
  ieee_t               w_cnv_data;
  flags_t              w_cnv_flags;
  logic                w_rnd;
  logic [5:0]          w_sub;
  logic                w_tap;
  logic                w_issue;
  logic                w_issue_ok;
  logic [31:0]         w_inflight;
  logic [CW-1:0]       w_fifo_count;
  logic                w_fifo_valid;
  logic [OUT_W-1:0]    w_fifo_dout;
  logic                w_pop;

  assign w_r     = flopoco_t'(bus.r);
  assign w_tap   = r_vld_dly[CORE_LAT-1];
  assign w_issue = bus.x_valid & w_issue_ok;

  always_ff @(posedge clk) begin
    if (rst) r_vld_dly <= '0;
    else     r_vld_dly <= (r_vld_dly << 1) | CORE_LAT'(w_issue);
  end

  // Subnormal: hidden one plus two fraction bits, f0 is the guard bit.
  assign w_rnd = w_r.frac[0] & w_r.frac[1];
  assign w_sub = {3'b000, 1'b1, w_r.frac[2:1]} + 6'(w_rnd);

  always_comb begin
    w_cnv_data  = '0;
    w_cnv_flags = '0;
    case (w_r.exn)
      EXN_ZERO: w_cnv_data = '{sign: w_r.sign, exp: '0, frac: '0};
      EXN_INF:  w_cnv_data = '{sign: w_r.sign, exp: EXP_MAX, frac: '0};
      EXN_NAN: begin
        w_cnv_data          = CANON_NAN;
        w_cnv_flags.invalid = 1'b1;
      end
      EXN_NORM: begin
        if (w_r.exp == EXP_MAX) begin
          w_cnv_data           = '{sign: w_r.sign, exp: EXP_MAX, frac: '0};
          w_cnv_flags.overflow = 1'b1;
        end else if (w_r.exp == '0) begin
          w_cnv_data            = ieee_t'({w_r.sign, w_sub});
          w_cnv_flags.underflow = w_r.frac[0];
        end else begin
          w_cnv_data = '{sign: w_r.sign, exp: w_r.exp, frac: w_r.frac};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnv_valid <= 1'b0;
      r_cnv_data  <= '0;
      r_cnv_flags <= '0;
    end else begin
      r_cnv_valid <= w_tap;
      r_cnv_data  <= w_cnv_data;
      r_cnv_flags <= w_cnv_flags;
    end
  end

  // Credits ignore a same-cycle pop, so the FIFO can never overflow.
  always_comb begin
    w_inflight = 32'(r_cnv_valid);
    for (int i = 0; i < CORE_LAT; i++) w_inflight = w_inflight + 32'(r_vld_dly[i]);
  end

  assign w_issue_ok = (32'(w_fifo_count) + w_inflight) < 32'(DEPTH);
  assign w_pop      = w_fifo_valid & bus.out_ready;

  fsqrt_drain_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_cnv_valid),
    .din   ({r_cnv_flags, r_cnv_data}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .valid (w_fifo_valid),
    .count (w_fifo_count)
  );

  assign bus.issue_ok  = w_issue_ok;
  assign bus.out_valid = w_fifo_valid;
  assign bus.out_flags = w_fifo_dout[OUT_W-1 -: 3];
  assign bus.out_data  = w_fifo_dout[6:0];

`ifdef FSQRT_DRAIN_STATS_EN
  logic [CNT_W-1:0] r_nan_cnt;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic             r_drop_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nan_cnt  <= '0;
      r_ovf_cnt  <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (r_cnv_valid && r_cnv_flags.invalid && r_nan_cnt != '1)
        r_nan_cnt <= r_nan_cnt + CNT_W'(1);
      if (r_cnv_valid && r_cnv_flags.overflow && r_ovf_cnt != '1)
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
      if (bus.x_valid && !w_issue_ok)
        r_drop_err <= 1'b1;
    end
  end

  assign nan_cnt  = r_nan_cnt;
  assign ovf_cnt  = r_ovf_cnt;
  assign drop_err = r_drop_err;
`endif

endmodule

`default_nettype wire

// File: doc/fsqrt_drain_3_3.md
Name: fsqrt_drain_3_3

Overview:
- Downstream consumer of the pipelined FloPoCo square-root core for the (wE=3, wF=3) format.
- Tracks validity of operands issued into the core, which has a fixed latency and no handshake.
- Converts each 9-bit FloPoCo result to a 7-bit IEEE-style word, with subnormals, rounding and flags.
- Buffers results in a FIFO with valid/ready output, and gives upstream a credit signal so no result is ever lost.

Parameters:
- CORE_LAT, 1, pipeline latency of the fsqrt core in cycles (>=1).
- DEPTH, 4, output FIFO entries (power of two, >=2).
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- x_valid  in  1  an operand X is presented to the fsqrt core this cycle.
- issue_ok  out  1  upstream may assert x_valid this cycle.
- r  in  9  core result R: [8:7] exception, [6] sign, [5:3] exponent (bias 3), [2:0] fraction.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  7  IEEE-style result: [6] sign, [5:3] exponent (bias 3), [2:0] fraction.
- out_flags  out  3  [2] invalid (NaN), [1] overflow, [0] underflow-inexact.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. While rst is high at a clock edge, the following are cleared:
  - valid delay line, convert-stage valid, FIFO pointers and count, counters.
  - Outputs after reset: out_valid=0, out_data=0, out_flags=0, issue_ok=1.
- Valid tracking: x_valid shifts through a CORE_LAT-deep delay line. The tap at depth CORE_LAT qualifies r in that cycle. r is ignored when the tap is 0.
- Convert stage: one register. Qualified r is converted combinationally, registered with convert-valid, and pushed into the FIFO the following cycle.
- Conversion on r:
  - exn=00: {s,000,000}.
  - exn=10: {s,111,000}.
  - exn=11: canonical NaN {0,111,100}, invalid flag set.
  - exn=01, exp 1..6: {s,exp,frac}, no flags.
  - exn=01, exp=7: {s,111,000}, overflow flag set.
  - exn=01, exp=0 (subnormal):
    - m={1,f2,f1}, g=f0, rnd=g&m[0] (round to nearest, ties to even).
    - Result {s, 6'({3'b000,m})+rnd}; a carry out of m naturally yields exponent 001.
    - Underflow flag set when g=1.
- FIFO: show-ahead, DEPTH entries of {flags,data}.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - Full FIFO with a pending push is impossible by the credit rule.
- First-result latency: x_valid at cycle t gives out_valid at t+CORE_LAT+2 when the FIFO is empty.
- Credit rule:
  - inflight = ones in delay line + convert-valid.
  - issue_ok = (fifo_count + inflight) < DEPTH.
  - A same-cycle pop is not counted (conservative).
  - x_valid while issue_ok=0 is a protocol violation; that operand is not tracked.
- Ordering: strictly in issue order.
- Reset mid-operation: in-flight and buffered results are discarded. Stale core outputs after reset are ignored because the delay line is cleared.

Optional Feature:
- FSQRT_DRAIN_STATS_EN defined:
  - Adds outputs nan_cnt and ovf_cnt [CNT_W-1:0], and a drop_err output (1 bit).
  - The counters are saturating and increment on FIFO push of a result with invalid or overflow set.
  - drop_err is a sticky bit set on x_valid & ~issue_ok.
  - All three are cleared by rst.
- Undefined: these ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fsqrt_fmt_pkg holds:
  - localparams WE=3, WF=3, BIAS=3.
  - Exception encodings EXN_ZERO/NORM/INF/NAN.
  - Packed struct for FloPoCo r and for IEEE out, flag struct, canonical NaN constant.
- Sub-module: fsqrt_drain_fifo, a generic show-ahead sync FIFO with a count output. Conversion stays inline in the top module.

Test Plan:
- Normal result: x_valid pulse at t=0, r=9'b01_0_101_011 at t=1 → out_data=7'b0_101_011, out_flags=000, out_valid at t=3 (CORE_LAT=1).
- Subnormal rounding:
  - r=01_0_000_011 → out_data=0_000_110, flags=001.
  - r=01_0_000_111 → out_data=0_001_000, flags=001.
  - r=01_0_000_100 → 0_000_110, flags=000.
- Specials:
  - r=11_1_010_101 → 0_111_100, flags=100.
  - r=01_1_111_001 → 1_111_000, flags=010.
  - r=10_0_xxx → 0_111_000, flags=000.
  - r=00_1_xxx → 1_000_000, flags=000.
- Backpressure with out_ready=0: issue 4 back-to-back operands → issue_ok=0 from the cycle after the 4th issue, and no loss. Then raise out_ready → results drain in order one per cycle, and issue_ok returns to 1 after the first pop.
- Reset mid-flight: 3 operands in flight, then rst for 1 cycle → out_valid=0 and issue_ok=1 the next cycle, with no stale result emitted afterwards.
- With FSQRT_DRAIN_STATS_EN:
  - Push 2 NaN and 1 overflow result → nan_cnt=2, ovf_cnt=1.
  - x_valid while issue_ok=0 → drop_err=1, staying set until rst.
